// File: rtl/core_sequencer.sv
// ============================================================================
// Module   : core_sequencer
// Purpose  : Multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb) with PC,
//            retired counter and sticky trap reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        exec_en,
  input  logic [31:0] next_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  input  logic        halt_req,
  output logic        halted,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_DECODE = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_MEM    = 3'd4;
  localparam logic [2:0] c_WB     = 3'd5;
  localparam logic [2:0] c_HALT   = 3'd6;
  localparam logic [2:0] c_TRAP   = 3'd7;

  localparam logic [6:0] c_OP_LOAD   = 7'h03;
  localparam logic [6:0] c_OP_STORE  = 7'h23;
  localparam logic [6:0] c_OP_BRANCH = 7'h63;
  localparam logic [6:0] c_OP_FENCE  = 7'h0f;
  localparam logic [6:0] c_OP_SYSTEM = 7'h73;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retired;
  logic [31:0] r_next_pc;
  logic [1:0]  r_cause;

  logic [6:0]  w_opcode;
  logic        w_legal;
  logic        w_env_call;
  logic        w_is_mem;
  logic        w_npc_misaligned;
  logic        w_rd_write;

  assign w_opcode = r_inst[6:0];

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      7'h17, 7'h37, 7'h6f, 7'h67, 7'h03, 7'h13,
      7'h0f, 7'h73, 7'h63, 7'h23, 7'h33: w_legal = 1'b1;
      default:                           w_legal = 1'b0;
    endcase
  end

  assign w_env_call = (w_opcode == c_OP_SYSTEM) && (r_inst[14:12] == 3'd0);
  assign w_is_mem   = (w_opcode == c_OP_LOAD) || (w_opcode == c_OP_STORE);
  // next_pc is captured while it is guaranteed valid so WB decisions and
  // rf_we depend only on registered state, never on a live input.
  assign w_npc_misaligned = (r_next_pc[1:0] != 2'b00);
  assign w_rd_write = (w_opcode != c_OP_BRANCH) && (w_opcode != c_OP_STORE) &&
                      (w_opcode != c_OP_FENCE) && (r_inst[11:7] != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   w_state_nxt = c_FETCH;
      c_FETCH:  if (imem_ready) w_state_nxt = c_DECODE;
      c_DECODE: w_state_nxt = (!w_legal || w_env_call) ? c_TRAP : c_EXEC;
      c_EXEC:   w_state_nxt = w_is_mem ? c_MEM : c_WB;
      c_MEM:    if (dmem_ready) w_state_nxt = c_WB;
      c_WB: begin
        if (w_npc_misaligned) w_state_nxt = c_TRAP;
        else if (halt_req)    w_state_nxt = c_HALT;
        else                  w_state_nxt = c_FETCH;
      end
      c_HALT:   if (!halt_req) w_state_nxt = c_FETCH;
      c_TRAP:   w_state_nxt = c_TRAP;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_inst    <= 32'h0000_0013;
      r_retired <= 32'd0;
      r_next_pc <= RESET_PC;
      r_cause   <= 2'd0;
    end else begin
      if ((r_state == c_FETCH) && imem_ready) r_inst <= imem_rdata;
      if ((r_state == c_EXEC) || (r_state == c_MEM)) r_next_pc <= next_pc;
      if (r_state == c_DECODE) begin
        if (!w_legal)        r_cause <= 2'd1;
        else if (w_env_call) r_cause <= 2'd2;
      end
      if (r_state == c_WB) begin
        if (w_npc_misaligned) begin
          r_cause <= 2'd3;
        end else begin
          r_pc      <= r_next_pc;
          r_retired <= r_retired + 32'd1;
        end
      end
    end
  end

  always_comb begin
    imem_req = 1'b0;
    exec_en  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    trap     = 1'b0;
    case (r_state)
      c_FETCH: imem_req = 1'b1;
      c_EXEC:  exec_en  = 1'b1;
      c_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_opcode == c_OP_STORE);
      end
      c_WB:    rf_we  = !w_npc_misaligned && w_rd_write;
      c_HALT:  halted = 1'b1;
      c_TRAP:  trap   = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign retired    = r_retired;
  assign trap_cause = r_cause;

endmodule

`default_nettype wire
